// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bundled core, fabric and SRAM port 0 signals of the data-memory arbiter
//
// Purpose: groups every bus signal of dmem_arbiter into one interface.
//   slave  modport : the arbiter's view (takes requests, drives grants/responses and the SRAM pins)
//   master modport : the environment's view (requesters plus the SRAM macro)
// Signal groups:
//   core_*  : Ibex data port, req/gnt/rvalid handshake, we/be/addr/wdata/rdata, err
//   fab_*   : eFPGA fabric master, same shape as core, plus fab_lock_i
//   sram_*  : sky130 32x256 macro port 0 (csb0/web0 active low, wmask0, addr0, din0, dout0)
interface dmem_arbiter_if #(
  parameter int AW = 8
);
  logic          core_req_i;
  logic          core_gnt_o;
  logic          core_rvalid_o;
  logic          core_err_o;
  logic          core_we_i;
  logic [3:0]    core_be_i;
  logic [31:0]   core_addr_i;
  logic [31:0]   core_wdata_i;
  logic [31:0]   core_rdata_o;

  logic          fab_req_i;
  logic          fab_gnt_o;
  logic          fab_rvalid_o;
  logic          fab_err_o;
  logic          fab_we_i;
  logic [3:0]    fab_be_i;
  logic [31:0]   fab_addr_i;
  logic [31:0]   fab_wdata_i;
  logic [31:0]   fab_rdata_o;
  logic          fab_lock_i;

  logic          sram_csb0_o;
  logic          sram_web0_o;
  logic [3:0]    sram_wmask0_o;
  logic [AW-1:0] sram_addr0_o;
  logic [31:0]   sram_din0_o;
  logic [31:0]   sram_dout0_i;

  modport slave (
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o,
    input  fab_req_i, fab_we_i, fab_be_i, fab_addr_i, fab_wdata_i, fab_lock_i,
    output fab_gnt_o, fab_rvalid_o, fab_err_o, fab_rdata_o,
    output sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
    input  sram_dout0_i
  );

  modport master (
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o,
    output fab_req_i, fab_we_i, fab_be_i, fab_addr_i, fab_wdata_i, fab_lock_i,
    input  fab_gnt_o, fab_rvalid_o, fab_err_o, fab_rdata_o,
    input  sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
    output sram_dout0_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing data SRAM port 0 between Ibex and the eFPGA fabric
//
// Purpose: zero-latency grant, one-cycle rvalid, round-robin between core and fabric, and a
//   bounded fabric lock (at most LOCK_MAX back-to-back locked grants, then one core-priority cycle).
// Ports:
//   clk   : block and SRAM clock
//   reset : asynchronous, active-high
//   bus   : dmem_arbiter_if.slave (core port, fabric port incl. fab_lock_i, SRAM port 0)
// Parameters:
//   AW       : SRAM word-address width, word index = addr[AW+1:2]
//   LOCK_MAX : locked fabric grants allowed before the core gets one priority cycle (1..255)
// Optional feature macro: DMEM_ARB_ADDR_CHECK_EN
//   defined   : nonzero addr[31:AW+2] is granted without touching the SRAM and answered with err
//   undefined : upper address bits alias, err outputs tied low
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_t;

  state_t     st, st_nxt;
  logic       last, last_nxt;        // 0 = core won last, 1 = fabric won last
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       resp_core, resp_fab;

  logic       core_win, fab_win, any_win;
  logic       lock_prio;             // lock budget spent: core goes first this cycle
  logic       lock_hold;             // fabric owns the port this cycle

  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        oob;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= ST_IDLE;
      last      <= 1'b1;
      lock_cnt  <= 8'd0;
      resp_core <= 1'b0;
      resp_fab  <= 1'b0;
    end else begin
      st        <= st_nxt;
      last      <= last_nxt;
      lock_cnt  <= lock_cnt_nxt;
      resp_core <= core_win;
      resp_fab  <= fab_win;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration and lock next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    core_win     = 1'b0;
    fab_win      = 1'b0;
    st_nxt       = st;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;

    lock_prio = (st == ST_LOCK) && (lock_cnt == LOCK_MAX_C);
    // Dropping fab_lock_i releases the lock in the same cycle, so normal
    // arbitration already applies to this cycle.
    lock_hold = (st == ST_LOCK) && bus.fab_lock_i && !lock_prio;

    if (!reset) begin
      if (lock_hold) begin
        fab_win = bus.fab_req_i;
      end else if (lock_prio) begin
        core_win = bus.core_req_i;
        fab_win  = !bus.core_req_i && bus.fab_req_i;
      end else begin
        unique case ({bus.core_req_i, bus.fab_req_i})
          2'b10:   core_win = 1'b1;
          2'b01:   fab_win  = 1'b1;
          2'b11: begin
            // Tie: the side that did not win last time goes.
            core_win = last;
            fab_win  = !last;
          end
          default: ;
        endcase
      end

      if (core_win) last_nxt = 1'b0;
      if (fab_win)  last_nxt = 1'b1;

      if (fab_win && bus.fab_lock_i) begin
        st_nxt       = ST_LOCK;
        // A locked grant outside an ongoing hold (fresh or in the core-priority
        // cycle) starts a new budget.
        lock_cnt_nxt = lock_hold ? lock_cnt + 8'd1 : 8'd1;
      end else if (!lock_hold) begin
        st_nxt = ST_IDLE;
      end
      // Holding with no fabric request keeps LOCK and the count as they are.
    end
  end

  assign any_win = core_win || fab_win;

  // ---------------------------------------------------------------------------
  // SRAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_we    = bus.core_we_i;
    sel_be    = bus.core_be_i;
    sel_addr  = bus.core_addr_i;
    sel_wdata = bus.core_wdata_i;
    if (fab_win) begin
      sel_we    = bus.fab_we_i;
      sel_be    = bus.fab_be_i;
      sel_addr  = bus.fab_addr_i;
      sel_wdata = bus.fab_wdata_i;
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic resp_err;
  logic unused_addr_bits;

  assign oob              = |sel_addr[31:AW+2];
  assign unused_addr_bits = ^sel_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) resp_err <= 1'b0;
    else       resp_err <= any_win && oob;
  end

  assign bus.core_err_o = resp_core && resp_err;
  assign bus.fab_err_o  = resp_fab && resp_err;
`else
  logic unused_addr_bits;

  // Upper bits alias into the macro; byte offset is irrelevant for word access.
  assign oob              = 1'b0;
  assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};

  assign bus.core_err_o = 1'b0;
  assign bus.fab_err_o  = 1'b0;
`endif

  always_comb begin
    bus.sram_csb0_o   = 1'b1;
    bus.sram_web0_o   = 1'b1;
    bus.sram_wmask0_o = 4'h0;
    bus.sram_addr0_o  = '0;
    bus.sram_din0_o   = 32'h0;
    if (any_win) begin
      // Out-of-range accesses are granted but never select the macro.
      bus.sram_csb0_o   = oob;
      bus.sram_web0_o   = ~sel_we;
      bus.sram_wmask0_o = sel_be;
      bus.sram_addr0_o  = sel_addr[AW+1:2];
      bus.sram_din0_o   = sel_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------------
  assign bus.core_gnt_o    = core_win;
  assign bus.fab_gnt_o     = fab_win;
  assign bus.core_rvalid_o = resp_core;
  assign bus.fab_rvalid_o  = resp_fab;
  // Read data comes straight from the macro; only meaningful under rvalid.
  assign bus.core_rdata_o  = bus.sram_dout0_i;
  assign bus.fab_rdata_o   = bus.sram_dout0_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with an SRAM model and reference model
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW)) bus();

  dmem_arbiter #(.AW(AW), .LOCK_MAX(LM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural SRAM macro: dout valid the cycle after a read access.
  logic [31:0] sram [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (!bus.sram_csb0_o) begin
      if (!bus.sram_web0_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask0_o[b])
            sram[bus.sram_addr0_o][8*b +: 8] <= bus.sram_din0_o[8*b +: 8];
      end else begin
        bus.sram_dout0_i <= sram[bus.sram_addr0_o];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mref [256] = '{default: 32'h0};
  bit          m_last_fab;   // who won the previous grant
  bit          m_locked;     // fabric currently owns the port
  int          m_run;        // locked fabric grants in the current run
  bit p_core, p_fab, p_err, p_chk;
  logic [31:0] p_rdata;
  bit last_cw, last_fw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_fab = 1'b1;
    m_locked   = 1'b0;
    m_run      = 0;
    p_core = 0; p_fab = 0; p_err = 0; p_chk = 0; p_rdata = 32'h0;
    last_cw = 0; last_fw = 0;
  endtask

  task automatic set_core(input bit req, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.core_req_i = req; bus.core_we_i = we; bus.core_be_i = be;
    bus.core_addr_i = addr; bus.core_wdata_i = wdata;
  endtask

  task automatic set_fab(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit lock);
    bus.fab_req_i = req; bus.fab_we_i = we; bus.fab_be_i = be;
    bus.fab_addr_i = addr; bus.fab_wdata_i = wdata; bus.fab_lock_i = lock;
  endtask

  // One clock cycle, entered and left at posedge+1 with inputs already applied.
  task automatic cycle();
    bit creq, freq, flock, cw, fw, g, we, oob, budget_spent, owned;
    logic [3:0]  be;
    logic [31:0] a, wd;
    int idx;

    // Responses to the previous cycle's grant
    chk("core_rvalid", bus.core_rvalid_o, p_core);
    chk("fab_rvalid", bus.fab_rvalid_o, p_fab);
    chk("core_err", bus.core_err_o, p_core && p_err);
    chk("fab_err", bus.fab_err_o, p_fab && p_err);
    if (p_chk && p_core) chk("core_rdata", bus.core_rdata_o, p_rdata);
    if (p_chk && p_fab)  chk("fab_rdata", bus.fab_rdata_o, p_rdata);

    #4;
    creq = bus.core_req_i; freq = bus.fab_req_i; flock = bus.fab_lock_i;
    budget_spent = m_locked && (m_run == LM);
    owned        = m_locked && flock && !budget_spent;
    cw = 0; fw = 0;
    if (owned)             fw = freq;
    else if (budget_spent) begin cw = creq; fw = freq && !creq; end
    else if (creq && freq) begin cw = m_last_fab; fw = !m_last_fab; end
    else                   begin cw = creq; fw = freq; end
    g = cw || fw;

    chk("core_gnt", bus.core_gnt_o, cw);
    chk("fab_gnt", bus.fab_gnt_o, fw);

    we = fw ? bus.fab_we_i    : bus.core_we_i;
    be = fw ? bus.fab_be_i    : bus.core_be_i;
    a  = fw ? bus.fab_addr_i  : bus.core_addr_i;
    wd = fw ? bus.fab_wdata_i : bus.core_wdata_i;
    idx = int'(a[9:2]);
`ifdef DMEM_ARB_ADDR_CHECK_EN
    oob = |a[31:10];
`else
    oob = 1'b0;
`endif
    chk("csb0", bus.sram_csb0_o, !(g && !oob));
    chk("web0", bus.sram_web0_o, g ? !we : 1'b1);
    chk("wmask0", bus.sram_wmask0_o, g ? be : 4'h0);
    chk("addr0", bus.sram_addr0_o, g ? a[9:2] : 8'h0);
    chk("din0", bus.sram_din0_o, g ? wd : 32'h0);

    p_core = cw; p_fab = fw; p_err = g && oob;
    p_chk  = g && !we && !oob;
    p_rdata = mref[idx];
    if (g && we && !oob)
      for (int b = 0; b < 4; b++)
        if (be[b]) mref[idx][8*b +: 8] = wd[8*b +: 8];

    if (g) m_last_fab = fw;
    if (fw && flock) begin
      m_run    = owned ? m_run + 1 : 1;
      m_locked = 1'b1;
    end else if (!owned) begin
      m_locked = 1'b0;
    end
    last_cw = cw; last_fw = fw;

    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic gen_core();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[31:10] = 22'h0;
    set_core($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a, $urandom);
  endtask

  task automatic gen_fab();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[31:10] = 22'h0;
    set_fab($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a, $urandom, bus.fab_lock_i);
  endtask

  initial begin
    logic [3:0] tie_seq;
    logic [5:0] lock_seq;

    model_reset();
    do_reset();

    // Core write then readback
    set_core(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    cycle();
    set_core(1, 0, 4'hF, 32'h10, 32'h0);
    cycle();
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    chk("core_readback", bus.core_rdata_o, 32'hDEADBEEF);
    cycle();

    // Round-robin tie after reset: core, fab, core, fab
    do_reset();
    set_core(1, 0, 4'hF, 32'h10, 32'h0);
    set_fab(1, 0, 4'hF, 32'h14, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      tie_seq[i] = last_cw;
    end
    chk("tie_order", tie_seq, 4'b0101);
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0, 0);
    cycle();

    // Bounded lock: fab x4, core, fab
    do_reset();
    set_core(1, 0, 4'hF, 32'h30, 32'h0);
    cycle();
    set_fab(1, 0, 4'hF, 32'h34, 32'h0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      lock_seq[i] = last_fw;
    end
    chk("lock_order", lock_seq, 6'b101111);
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0, 0);
    cycle();

    // Fabric byte write over an existing word
    set_fab(1, 1, 4'hF, 32'h20, 32'h11223344, 0);
    cycle();
    set_fab(1, 1, 4'h1, 32'h20, 32'h000000AA, 0);
    cycle();
    set_fab(1, 0, 4'hF, 32'h20, 32'h0, 0);
    cycle();
    set_fab(0, 0, 4'h0, 32'h0, 32'h0, 0);
    chk("fab_byte_merge", bus.fab_rdata_o, 32'h112233AA);
    cycle();

`ifdef DMEM_ARB_ADDR_CHECK_EN
    set_core(1, 0, 4'hF, 32'h400, 32'h0);
    cycle();
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    chk("oob_rvalid", bus.core_rvalid_o, 1'b1);
    chk("oob_err", bus.core_err_o, 1'b1);
    cycle();
`endif

    // Reset pulsed the cycle after a core grant
    set_core(1, 0, 4'hF, 32'h44, 32'h0);
    cycle();
    reset = 1'b1;
    #1;
    chk("rst_core_rvalid", bus.core_rvalid_o, 1'b0);
    chk("rst_fab_rvalid", bus.fab_rvalid_o, 1'b0);
    chk("rst_core_gnt", bus.core_gnt_o, 1'b0);
    chk("rst_core_err", bus.core_err_o, 1'b0);
    chk("rst_csb0", bus.sram_csb0_o, 1'b1);
    chk("rst_web0", bus.sram_web0_o, 1'b1);
    chk("rst_wmask0", bus.sram_wmask0_o, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    set_fab(1, 0, 4'hF, 32'h48, 32'h0, 0);
    cycle();
    chk("post_rst_tie_core", last_cw, 1'b1);
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0, 0);
    cycle();

    // Randomised traffic; requests stay stable until granted
    for (int i = 0; i < 600; i++) begin
      if (!bus.core_req_i || last_cw) gen_core();
      if (!bus.fab_req_i || last_fw) gen_fab();
      bus.fab_lock_i = ($urandom_range(0, 2) == 0);
      cycle();
    end
    set_core(0, 0, 4'h0, 32'h0, 32'h0);
    set_fab(0, 0, 4'h0, 32'h0, 32'h0, 0);
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
